fractal_sync_cnt_local_rf: RTL and testbench
============================================

FRACTAL_SYNC_CNT_LOCAL_RF -- requirements
Module: fractal_sync_cnt_local_rf

Interface
REQ-001 Clocking/reset: the block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Param ID_WIDTH, 2: barrier id width; bit 0 is level select, bits [ID_WIDTH-1:1] are local id.
REQ-003 Param N_REGS, 4: barrier entries.
REQ-004 Param N_PORTS, 4: request ports, >= 2.
REQ-005 Param CNT_WIDTH, 3: arrival-count and threshold width.
REQ-006 Param TIMEOUT_CYCLES, 1024: watchdog limit, used only under REQ-030.
REQ-007 clk_i  in  1  clock.
REQ-008 rst_i  in  1  async active-high reset.
REQ-009 id_i[N_PORTS]  in  ID_WIDTH  barrier id per port.
REQ-010 check_i[N_PORTS]  in  1  arrival valid per port.
REQ-011 sd_i[N_PORTS]  in  SD_WIDTH  source mask of arrival.
REQ-012 thr_i[N_PORTS]  in  CNT_WIDTH  arrivals required to complete barrier.
REQ-013 present_o[N_PORTS]  out  1  barrier completed; respond on this port.
REQ-014 sd_o[N_PORTS]  out  SD_WIDTH  OR of all arrival masks of the completed barrier, else 0.
REQ-015 id_err_o[N_PORTS]  out  1  local id > N_REGS-1.
REQ-016 bypass_o / ignore_o[N_PORTS]  out  1  same-cycle merge leader / merged follower.
REQ-017 to_err_o  out  1  timeout pulse; to_id_o  out  ID_WIDTH-1  local id timed out.

Function
REQ-018 Ports with check_i=1 and valid id sharing a local id in one cycle SHALL merge: lowest index is leader (bypass_o=1 iff >= 1 follower); others set ignore_o=1, present_o=0, sd_o=0.
REQ-019 Per entry state: pending flag, cnt_q, thr_q, sd_q; idle entry has all zero.
REQ-020 Leader arrival count a = 1 + followers; merged mask m = OR of group sd_i; total = cnt_q + a (saturating at 2**CNT_WIDTH-1).
REQ-021 Effective threshold: thr_q if pending, else leader thr_i; thr_i of 0 treated as 1; follower/later thr_i ignored.
REQ-022 If total >= threshold: present_o=1 combinationally in the same cycle on the leader, sd_o = sd_q | m; entry SHALL be idle after the next edge.
REQ-023 Else: at next edge pending=1, cnt_q=total, sd_q=sd_q|m, thr_q=threshold; present_o=0.
REQ-024 Invalid id: id_err_o=1, no state change, no merge participation, present_o=0.
REQ-025 Different local ids in one cycle SHALL update independently; all N_PORTS may complete in one cycle.
REQ-026 present_o SHALL be 0 whenever check_i=0; outputs are purely combinational from inputs and state (no added latency).

Reset
REQ-027 rst_i=1 SHALL clear all entries and watchdog counters immediately; all outputs then depend only on inputs (present_o=0 unless thr<=a).
REQ-028 Reset mid-barrier SHALL discard partial counts; post-reset arrivals start fresh.

Configuration
REQ-029 Macro FRACTAL_SYNC_LOCAL_RF_TIMEOUT_EN.
REQ-030 Defined: per-entry age counter increments each cycle while pending, clears on any arrival to the entry; reaching TIMEOUT_CYCLES clears the entry, pulses to_err_o for one cycle with to_id_o; lowest id wins if several time out, others retried next cycle (counter holds at limit); arrival and timeout in same cycle: arrival wins.
REQ-031 Undefined: no age counters; to_err_o=0, to_id_o=0.

Structure
REQ-032 fractal_sync_pkg SHALL hold SD_WIDTH and the entry struct typedef (pending, cnt, thr, sd).
REQ-033 Merge/leader logic SHALL be sub-module fractal_sync_req_merge (outputs leader, follower, count, merged mask per port).

Verification
REQ-034 Port0 id=2 thr=3 sd=0x1; next cycles port1 id=2 sd=0x2, port2 id=2 sd=0x4 -> present_o[2]=1, sd_o[2]=0x7 on third arrival; entry idle next cycle.
REQ-035 Ports0,1,3 id=4 (local 2) thr=3 same cycle -> bypass_o[0]=1, ignore_o[1,3]=1, present_o[0]=1, sd_o[0]=OR of three masks.
REQ-036 N_REGS=4, id with local id 5 -> id_err_o=1, present_o=0, state unchanged.
REQ-037 Two arrivals of thr=4 barrier, rst_i pulse, then four arrivals -> completes only on fourth post-reset arrival.
REQ-038 Macro on, TIMEOUT_CYCLES=8, one arrival thr=2, idle 8 cycles -> to_err_o one-cycle pulse with to_id_o=local id; later single arrival does not complete.

Source files
------------

// File: rtl/fractal_sync_pkg.sv
// Shared types for the local fractal-sync barrier register file.
// Entry counters are stored at MAX_CNT_WIDTH and saturated to the instance width.
package fractal_sync_pkg;

  localparam int SD_WIDTH      = 4;
  localparam int MAX_CNT_WIDTH = 8;

  typedef logic [MAX_CNT_WIDTH-1:0] cnt_t;
  typedef logic [SD_WIDTH-1:0]      sd_t;

  typedef struct packed {
    logic pending;
    cnt_t cnt;
    cnt_t thr;
    sd_t  sd;
  } entry_t;

  function automatic cnt_t sat_add(
    input cnt_t a,
    input cnt_t b,
    input cnt_t lim
  );
    logic [MAX_CNT_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, lim}) ? lim : s[MAX_CNT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/fractal_sync_req_merge.sv
// Same-cycle arrival merge: lowest valid port per local id leads,
// and carries the group's arrival count and OR-ed source mask.
module fractal_sync_req_merge
  import fractal_sync_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int LID_W   = 1,
  parameter int CW      = 3
) (
  input  logic             valid_i    [N_PORTS],
  input  logic [LID_W-1:0] lid_i      [N_PORTS],
  input  sd_t              sd_i       [N_PORTS],
  output logic             leader_o   [N_PORTS],
  output logic             follower_o [N_PORTS],
  output logic [CW-1:0]    count_o    [N_PORTS],
  output sd_t              mask_o     [N_PORTS]
);

  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      follower_o[p] = 1'b0;
      leader_o[p]   = 1'b0;
      count_o[p]    = '0;
      mask_o[p]     = '0;
      for (int q = 0; q < N_PORTS; q++) begin
        if (q < p && valid_i[q] && valid_i[p] &&
            lid_i[q] == lid_i[p]) begin
          follower_o[p] = 1'b1;
        end
      end
      leader_o[p] = valid_i[p] && !follower_o[p];
      if (leader_o[p]) begin
        for (int q = 0; q < N_PORTS; q++) begin
          if (q >= p && valid_i[q] && lid_i[q] == lid_i[p]) begin
            count_o[p] = count_o[p] + CW'(1);
            mask_o[p]  = mask_o[p] | sd_i[q];
          end
        end
      end
    end
  end

endmodule

// File: rtl/fractal_sync_cnt_local_rf.sv
// Local barrier register file: counts arrivals per local id and completes combinationally.
// Optional watchdog: define FRACTAL_SYNC_LOCAL_RF_TIMEOUT_EN.
module fractal_sync_cnt_local_rf
  import fractal_sync_pkg::*;
#(
  parameter int ID_WIDTH       = 2,
  parameter int N_REGS         = 4,
  parameter int N_PORTS        = 4,
  parameter int CNT_WIDTH      = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ID_WIDTH-1:0] id_i      [N_PORTS],
  input  logic                check_i   [N_PORTS],
  input  sd_t                 sd_i      [N_PORTS],
  input  logic [CNT_WIDTH-1:0] thr_i    [N_PORTS],
  output logic                present_o [N_PORTS],
  output sd_t                 sd_o      [N_PORTS],
  output logic                id_err_o  [N_PORTS],
  output logic                bypass_o  [N_PORTS],
  output logic                ignore_o  [N_PORTS],
  output logic                to_err_o,
  output logic [ID_WIDTH-2:0] to_id_o
);

  localparam int   LID_W   = ID_WIDTH - 1;
  localparam int   CW      = $clog2(N_PORTS + 1);
  localparam cnt_t CNT_MAX = cnt_t'((1 << CNT_WIDTH) - 1);

  logic [LID_W-1:0] lid      [N_PORTS];
  logic             err      [N_PORTS];
  logic             valid    [N_PORTS];
  logic             leader   [N_PORTS];
  logic             follower [N_PORTS];
  logic [CW-1:0]    count    [N_PORTS];
  sd_t              mask     [N_PORTS];
  entry_t           sel_e    [N_PORTS];
  cnt_t             thr_in   [N_PORTS];
  cnt_t             thr_eff  [N_PORTS];
  cnt_t             total    [N_PORTS];
  logic             done     [N_PORTS];

  entry_t entry_q  [N_REGS];
  entry_t entry_d  [N_REGS];
  entry_t ent_arr  [N_REGS];
  logic   arrival  [N_REGS];
  logic   unused_lvl;

  always_comb begin
    unused_lvl = 1'b0;
    for (int p = 0; p < N_PORTS; p++) begin
      lid[p]     = id_i[p][ID_WIDTH-1:1];
      unused_lvl = unused_lvl ^ id_i[p][0];
      err[p]     = 32'(lid[p]) > 32'(N_REGS - 1);
      valid[p]   = check_i[p] && !err[p];
    end
  end

  fractal_sync_req_merge #(
    .N_PORTS (N_PORTS),
    .LID_W   (LID_W),
    .CW      (CW)
  ) u_merge (
    .valid_i    (valid),
    .lid_i      (lid),
    .sd_i       (sd_i),
    .leader_o   (leader),
    .follower_o (follower),
    .count_o    (count),
    .mask_o     (mask)
  );

  always_comb begin
    ent_arr = entry_q;
    for (int r = 0; r < N_REGS; r++) arrival[r] = 1'b0;
    for (int p = 0; p < N_PORTS; p++) begin
      present_o[p] = 1'b0;
      sd_o[p]      = '0;
      bypass_o[p]  = 1'b0;
      ignore_o[p]  = follower[p];
      id_err_o[p]  = check_i[p] && err[p];
      sel_e[p]     = '0;
      for (int r = 0; r < N_REGS; r++) begin
        if (32'(lid[p]) == r) sel_e[p] = entry_q[r];
      end
      thr_in[p]  = (thr_i[p] == '0) ? cnt_t'(1) : cnt_t'(thr_i[p]);
      thr_eff[p] = sel_e[p].pending ? sel_e[p].thr : thr_in[p];
      total[p]   = sat_add(sel_e[p].cnt, cnt_t'(count[p]), CNT_MAX);
      done[p]    = total[p] >= thr_eff[p];
      if (leader[p]) begin
        bypass_o[p]  = count[p] > CW'(1);
        present_o[p] = done[p];
        sd_o[p]      = done[p] ? (sel_e[p].sd | mask[p]) : '0;
        for (int r = 0; r < N_REGS; r++) begin
          if (32'(lid[p]) == r) begin
            arrival[r] = 1'b1;
            if (done[p]) ent_arr[r] = '0;
            else ent_arr[r] = '{pending: 1'b1, cnt: total[p],
                                thr: thr_eff[p],
                                sd: sel_e[p].sd | mask[p]};
          end
        end
      end
    end
  end

`ifdef FRACTAL_SYNC_LOCAL_RF_TIMEOUT_EN
  localparam int AGE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(TIMEOUT_CYCLES);

  logic [AGE_W-1:0] age_q [N_REGS];
  logic [AGE_W-1:0] age_d [N_REGS];
  logic             expired [N_REGS];

  always_comb begin
    entry_d  = ent_arr;
    to_err_o = 1'b0;
    to_id_o  = '0;
    for (int r = 0; r < N_REGS; r++) begin
      expired[r] = entry_q[r].pending && !arrival[r] &&
                   age_q[r] == AGE_LIM;
      // Only the lowest expired id is reported; the rest hold at the limit.
      if (expired[r] && !to_err_o) begin
        to_err_o   = 1'b1;
        to_id_o    = LID_W'(r);
        entry_d[r] = '0;
      end
    end
    for (int r = 0; r < N_REGS; r++) begin
      age_d[r] = '0;
      if (entry_d[r].pending && !arrival[r]) begin
        age_d[r] = (age_q[r] == AGE_LIM) ? AGE_LIM : age_q[r] + AGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < N_REGS; r++) age_q[r] <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`else
  always_comb begin
    entry_d  = ent_arr;
    to_err_o = 1'b0;
    to_id_o  = '0;
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < N_REGS; r++) entry_q[r] <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

endmodule

// File: tb/tb_fractal_sync_cnt_local_rf.sv
// Directed bench for the local barrier register file.
// Exercises sequential arrivals, merging, invalid ids, reset and the optional watchdog.
module tb_fractal_sync_cnt_local_rf;
  import fractal_sync_pkg::*;

  localparam int IDW = 4;
  localparam int NP  = 4;
  localparam int CNW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [IDW-1:0] id      [NP];
  logic           check   [NP];
  sd_t            sd      [NP];
  logic [CNW-1:0] thr     [NP];
  logic           present [NP];
  sd_t            sd_out  [NP];
  logic           id_err  [NP];
  logic           bypass  [NP];
  logic           ignore  [NP];
  logic           to_err;
  logic [IDW-2:0] to_id;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  fractal_sync_cnt_local_rf #(
    .ID_WIDTH       (IDW),
    .N_REGS         (4),
    .N_PORTS        (NP),
    .CNT_WIDTH      (CNW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .id_i      (id),
    .check_i   (check),
    .sd_i      (sd),
    .thr_i     (thr),
    .present_o (present),
    .sd_o      (sd_out),
    .id_err_o  (id_err),
    .bypass_o  (bypass),
    .ignore_o  (ignore),
    .to_err_o  (to_err),
    .to_id_o   (to_id)
  );

  task automatic clr_in();
    for (int p = 0; p < NP; p++) begin
      id[p] = '0; check[p] = 1'b0; sd[p] = '0; thr[p] = '0;
    end
  endtask

  task automatic drive(input int p, input int i, input int t, input int s);
    id[p] = IDW'(i); check[p] = 1'b1; thr[p] = CNW'(t); sd[p] = SD_WIDTH'(s);
  endtask

  task automatic step();
    @(posedge clk); #1;
    clr_in();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr_in();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (present[0] !== 1'b0 || sd_out[0] !== 4'h0) begin
      failed++; $display("FAIL reset_idle present=%b sd=%h want 0/0", present[0], sd_out[0]);
    end
    drive(0, 2, 1, 1); #1;
    tests++;
    if (present[0] !== 1'b1 || sd_out[0] !== 4'h1) begin
      failed++; $display("FAIL reset_thr1 present=%b sd=%h want 1/1", present[0], sd_out[0]);
    end
    @(posedge clk); #1;
    tests++;
    if (present[0] !== 1'b1) begin
      failed++; $display("FAIL reset_hold present=%b want 1", present[0]);
    end
    clr_in(); rst = 1'b0; #1;
    tests++;
    if (to_err !== 1'b0 || to_id !== 3'd0) begin
      failed++; $display("FAIL reset_to to_err=%b to_id=%0d want 0/0", to_err, to_id);
    end
  endtask

  task automatic test_sequential();
    drive(0, 2, 3, 1); #1;
    tests++;
    if (present[0] !== 1'b0 || bypass[0] !== 1'b0 || ignore[0] !== 1'b0) begin
      failed++; $display("FAIL seq_a present=%b bypass=%b ignore=%b want 0/0/0", present[0], bypass[0], ignore[0]);
    end
    step();
    drive(1, 2, 0, 2); #1;
    tests++;
    if (present[1] !== 1'b0 || present[0] !== 1'b0 || sd_out[0] !== 4'h0) begin
      failed++; $display("FAIL seq_b present1=%b present0=%b sd0=%h want 0/0/0", present[1], present[0], sd_out[0]);
    end
    step();
    drive(2, 2, 7, 4); #1;
    tests++;
    if (present[2] !== 1'b1 || sd_out[2] !== 4'h7) begin
      failed++; $display("FAIL seq_c present=%b sd=%h want 1/7", present[2], sd_out[2]);
    end
    step();
    drive(3, 2, 1, 8); #1;
    tests++;
    if (present[3] !== 1'b1 || sd_out[3] !== 4'h8) begin
      failed++; $display("FAIL seq_idle present=%b sd=%h want 1/8", present[3], sd_out[3]);
    end
    step();
  endtask

  task automatic test_merge();
    drive(0, 4, 3, 1); drive(1, 4, 3, 2); drive(3, 4, 3, 8); #1;
    tests++;
    if (bypass[0] !== 1'b1 || ignore[1] !== 1'b1 || ignore[3] !== 1'b1 || ignore[0] !== 1'b0) begin
      failed++; $display("FAIL merge_roles bypass0=%b ign1=%b ign3=%b ign0=%b want 1/1/1/0", bypass[0], ignore[1], ignore[3], ignore[0]);
    end
    tests++;
    if (present[0] !== 1'b1 || sd_out[0] !== 4'hB) begin
      failed++; $display("FAIL merge_lead present=%b sd=%h want 1/b", present[0], sd_out[0]);
    end
    tests++;
    if (present[1] !== 1'b0 || present[3] !== 1'b0 || sd_out[1] !== 4'h0 || sd_out[3] !== 4'h0) begin
      failed++; $display("FAIL merge_follow p1=%b p3=%b sd1=%h sd3=%h want 0/0/0/0", present[1], present[3], sd_out[1], sd_out[3]);
    end
    step();
    drive(0, 4, 2, 1); drive(2, 4, 2, 4); #1;
    tests++;
    if (present[0] !== 1'b1 || sd_out[0] !== 4'h5 || bypass[0] !== 1'b1 || ignore[2] !== 1'b1) begin
      failed++; $display("FAIL merge_pair present=%b sd=%h bypass=%b ign2=%b want 1/5/1/1", present[0], sd_out[0], bypass[0], ignore[2]);
    end
    step();
  endtask

  task automatic test_id_err();
    drive(0, 10, 1, 1); drive(1, 10, 1, 2); drive(2, 6, 2, 1); #1;
    tests++;
    if (id_err[0] !== 1'b1 || id_err[1] !== 1'b1 || id_err[2] !== 1'b0) begin
      failed++; $display("FAIL err_flag e0=%b e1=%b e2=%b want 1/1/0", id_err[0], id_err[1], id_err[2]);
    end
    tests++;
    if (present[0] !== 1'b0 || present[1] !== 1'b0 || bypass[0] !== 1'b0 || ignore[1] !== 1'b0) begin
      failed++; $display("FAIL err_merge p0=%b p1=%b bypass0=%b ign1=%b want 0/0/0/0", present[0], present[1], bypass[0], ignore[1]);
    end
    step();
    drive(2, 6, 0, 2); #1;
    tests++;
    if (present[2] !== 1'b1 || sd_out[2] !== 4'h3) begin
      failed++; $display("FAIL err_state present=%b sd=%h want 1/3", present[2], sd_out[2]);
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic got [4];
    for (int k = 0; k < 2; k++) begin
      drive(1, 6, 4, 1); #1;
      step();
    end
    rst = 1'b1; #2; rst = 1'b0; #2;
    for (int k = 0; k < 4; k++) begin
      drive(1, 6, 4, 2); #1;
      got[k] = present[1];
      step();
    end
    tests++;
    if (got[0] !== 1'b0 || got[1] !== 1'b0 || got[2] !== 1'b0 || got[3] !== 1'b1) begin
      failed++; $display("FAIL reset_mid seq=%b%b%b%b want 0001", got[0], got[1], got[2], got[3]);
    end
  endtask

  task automatic test_parallel();
    drive(0, 0, 1, 1); drive(1, 2, 0, 2); drive(2, 4, 1, 4); drive(3, 7, 1, 8); #1;
    tests++;
    if (present[0] !== 1'b1 || present[1] !== 1'b1 || present[2] !== 1'b1 || present[3] !== 1'b1) begin
      failed++; $display("FAIL par_present %b%b%b%b want 1111", present[0], present[1], present[2], present[3]);
    end
    tests++;
    if (sd_out[0] !== 4'h1 || sd_out[1] !== 4'h2 || sd_out[2] !== 4'h4 || sd_out[3] !== 4'h8) begin
      failed++; $display("FAIL par_sd %h %h %h %h want 1 2 4 8", sd_out[0], sd_out[1], sd_out[2], sd_out[3]);
    end
    step();
    drive(0, 2, 7, 1); drive(1, 2, 7, 1); drive(2, 2, 7, 1); drive(3, 2, 7, 1); #1;
    tests++;
    if (present[0] !== 1'b0) begin
      failed++; $display("FAIL sat_first present=%b want 0", present[0]);
    end
    step();
    drive(0, 2, 1, 2); drive(1, 2, 1, 2); drive(2, 2, 1, 2); drive(3, 2, 1, 2); #1;
    tests++;
    if (present[0] !== 1'b1 || sd_out[0] !== 4'h3) begin
      failed++; $display("FAIL sat_done present=%b sd=%h want 1/3", present[0], sd_out[0]);
    end
    step();
  endtask

  task automatic test_timeout();
    int seen;
    int pulses;
    seen = -1; pulses = 0;
    drive(0, 2, 2, 1); #1;
    step();
    for (int i = 0; i < 20; i++) begin
      if (to_err === 1'b1) begin
        pulses++;
        if (seen < 0) seen = i;
        tests++;
        if (to_id !== 3'd1) begin
          failed++; $display("FAIL to_id got=%0d want 1", to_id);
        end
      end
      @(posedge clk); #2;
    end
`ifdef FRACTAL_SYNC_LOCAL_RF_TIMEOUT_EN
    tests++;
    if (seen !== 8 || pulses !== 1) begin
      failed++; $display("FAIL to_pulse at=%0d count=%0d want 8/1", seen, pulses);
    end
    drive(0, 2, 2, 2); #1;
    tests++;
    if (present[0] !== 1'b0) begin
      failed++; $display("FAIL to_cleared present=%b want 0", present[0]);
    end
`else
    tests++;
    if (pulses !== 0 || to_id !== 3'd0) begin
      failed++; $display("FAIL to_off pulses=%0d to_id=%0d want 0/0", pulses, to_id);
    end
    drive(0, 2, 2, 2); #1;
    tests++;
    if (present[0] !== 1'b1 || sd_out[0] !== 4'h3) begin
      failed++; $display("FAIL to_off_done present=%b sd=%h want 1/3", present[0], sd_out[0]);
    end
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_merge();
    test_id_err();
    test_reset_mid();
    test_parallel();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
